// File: rtl/sf_tester_pattern_checker.sv
// ============================================================================
// Module : sf_tester_pattern_checker
// Brief  : Regenerates the A-D start/increment flash pattern and checks read-back
//          bytes against it. Optional SF_CHECKER_STOP_ON_ERR_EN ends a run on
//          the first mismatch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sf_tester_pattern_checker #(
   parameter int PARM_BYTE_COUNT = 1048576,
   parameter int PARM_ADDR_WIDTH = 25,
   parameter int PARM_ERR_WIDTH  = 32
) (
   input  logic                       i_clk_20mhz,
   input  logic                       i_rst_20mhz,
   input  logic                       i_start,
   input  logic [1:0]                 i_pattern_sel,
   input  logic [PARM_ADDR_WIDTH-1:0] i_start_addr,
   input  logic [7:0]                 i_rd_data,
   input  logic                       i_rd_valid,
   output logic                       o_rd_ready,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_pass,
   output logic [PARM_ERR_WIDTH-1:0]  o_err_count,
   output logic [31:0]                o_bytes_checked,
   output logic                       o_first_err_valid,
   output logic [PARM_ADDR_WIDTH-1:0] o_first_err_addr,
   output logic [7:0]                 o_first_err_exp,
   output logic [7:0]                 o_first_err_act
);

   localparam logic [31:0]                C_BYTE_COUNT = 32'(PARM_BYTE_COUNT);
   localparam logic [PARM_ADDR_WIDTH-1:0] C_ADDR_ONE   = 1;
   localparam logic [PARM_ERR_WIDTH-1:0]  C_ERR_ONE    = 1;
   localparam logic [PARM_ERR_WIDTH-1:0]  C_ERR_MAX    = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [7:0]                 exp_q, exp_d;
   logic [7:0]                 incr_q, incr_d;
   logic [PARM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [PARM_ERR_WIDTH-1:0]  err_q, err_d;
   logic [31:0]                bytes_q, bytes_d;
   logic                       pass_q, pass_d;
   logic                       fe_valid_q, fe_valid_d;
   logic [PARM_ADDR_WIDTH-1:0] fe_addr_q, fe_addr_d;
   logic [7:0]                 fe_exp_q, fe_exp_d;
   logic [7:0]                 fe_act_q, fe_act_d;

   logic w_accept;
   logic w_mismatch;

   assign w_accept   = i_rd_valid && (state_q == ST_CHECK);
   assign w_mismatch = w_accept && (i_rd_data != exp_q);

   always_comb begin
      state_d    = state_q;
      exp_d      = exp_q;
      incr_d     = incr_q;
      addr_d     = addr_q;
      err_d      = err_q;
      bytes_d    = bytes_q;
      pass_d     = pass_q;
      fe_valid_d = fe_valid_q;
      fe_addr_d  = fe_addr_q;
      fe_exp_d   = fe_exp_q;
      fe_act_d   = fe_act_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d    = ST_CHECK;
               addr_d     = i_start_addr;
               err_d      = '0;
               bytes_d    = '0;
               pass_d     = 1'b0;
               fe_valid_d = 1'b0;
               fe_addr_d  = '0;
               fe_exp_d   = '0;
               fe_act_d   = '0;
               case (i_pattern_sel)
                  2'd0:    begin exp_d = 8'h00; incr_d = 8'h01; end
                  2'd1:    begin exp_d = 8'h08; incr_d = 8'h07; end
                  2'd2:    begin exp_d = 8'h10; incr_d = 8'h0F; end
                  default: begin exp_d = 8'h18; incr_d = 8'h17; end
               endcase
            end
         end

         ST_CHECK: begin
            if (w_accept) begin
               exp_d   = exp_q + incr_q;
               addr_d  = addr_q + C_ADDR_ONE;
               bytes_d = bytes_q + 32'd1;
               if (w_mismatch) begin
                  if (err_q != C_ERR_MAX) begin
                     err_d = err_q + C_ERR_ONE;
                  end
                  if (!fe_valid_q) begin
                     fe_valid_d = 1'b1;
                     fe_addr_d  = addr_q;
                     fe_exp_d   = exp_q;
                     fe_act_d   = i_rd_data;
                  end
               end
               if (bytes_q + 32'd1 == C_BYTE_COUNT) begin
                  state_d = ST_DONE;
               end
`ifdef SF_CHECKER_STOP_ON_ERR_EN
               if (w_mismatch) begin
                  state_d = ST_DONE;
               end
`endif
            end
         end

         ST_DONE: begin
            // err_q already includes any mismatch on the final accepted byte
            pass_d  = (err_q == '0);
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_20mhz) begin
      if (i_rst_20mhz) begin
         state_q    <= ST_IDLE;
         exp_q      <= '0;
         incr_q     <= '0;
         addr_q     <= '0;
         err_q      <= '0;
         bytes_q    <= '0;
         pass_q     <= 1'b0;
         fe_valid_q <= 1'b0;
         fe_addr_q  <= '0;
         fe_exp_q   <= '0;
         fe_act_q   <= '0;
      end else begin
         state_q    <= state_d;
         exp_q      <= exp_d;
         incr_q     <= incr_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
         bytes_q    <= bytes_d;
         pass_q     <= pass_d;
         fe_valid_q <= fe_valid_d;
         fe_addr_q  <= fe_addr_d;
         fe_exp_q   <= fe_exp_d;
         fe_act_q   <= fe_act_d;
      end
   end

   assign o_rd_ready        = (state_q == ST_CHECK);
   assign o_busy            = (state_q != ST_IDLE);
   assign o_done            = (state_q == ST_DONE);
   assign o_pass            = pass_q;
   assign o_err_count       = err_q;
   assign o_bytes_checked   = bytes_q;
   assign o_first_err_valid = fe_valid_q;
   assign o_first_err_addr  = fe_addr_q;
   assign o_first_err_exp   = fe_exp_q;
   assign o_first_err_act   = fe_act_q;

endmodule

`default_nettype wire

// File: tb/tb_sf_tester_pattern_checker.sv
// ============================================================================
// Module : tb_sf_tester_pattern_checker
// Brief  : Randomized self-checking bench for sf_tester_pattern_checker against a
//          pattern-formula reference model (16-byte runs).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sf_tester_pattern_checker;

   localparam int N  = 16;
   localparam int AW = 25;
`ifdef SF_CHECKER_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0;
   logic [1:0]    i_pattern_sel = '0;
   logic [AW-1:0] i_start_addr = '0;
   logic [7:0]    i_rd_data = '0;
   logic          i_rd_valid = 1'b0;
   logic          o_rd_ready, o_busy, o_done, o_pass, o_first_err_valid;
   logic [31:0]   o_err_count, o_bytes_checked;
   logic [AW-1:0] o_first_err_addr;
   logic [7:0]    o_first_err_exp, o_first_err_act;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] stream [N];
   logic [7:0] pat_start [4] = '{8'h00, 8'h08, 8'h10, 8'h18};
   logic [7:0] pat_incr  [4] = '{8'h01, 8'h07, 8'h0F, 8'h17};

   sf_tester_pattern_checker #(
      .PARM_BYTE_COUNT(N),
      .PARM_ADDR_WIDTH(AW),
      .PARM_ERR_WIDTH (32)
   ) dut (
      .i_clk_20mhz      (clk),
      .i_rst_20mhz      (rst),
      .i_start          (i_start),
      .i_pattern_sel    (i_pattern_sel),
      .i_start_addr     (i_start_addr),
      .i_rd_data        (i_rd_data),
      .i_rd_valid       (i_rd_valid),
      .o_rd_ready       (o_rd_ready),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_pass           (o_pass),
      .o_err_count      (o_err_count),
      .o_bytes_checked  (o_bytes_checked),
      .o_first_err_valid(o_first_err_valid),
      .o_first_err_addr (o_first_err_addr),
      .o_first_err_exp  (o_first_err_exp),
      .o_first_err_act  (o_first_err_act)
   );

   always #25 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int sel, input int n);
      int v;
      v = int'(pat_start[sel]) + n * int'(pat_incr[sel]);
      return 8'(v % 256);
   endfunction

   function automatic void set_good(input int sel);
      for (int n = 0; n < N; n++) stream[n] = exp_byte(sel, n);
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"},  32'(o_busy), 0);
      check_eq({tag, "_done"},  32'(o_done), 0);
      check_eq({tag, "_ready"}, 32'(o_rd_ready), 0);
      check_eq({tag, "_pass"},  32'(o_pass), 0);
      check_eq({tag, "_err"},   o_err_count, 0);
      check_eq({tag, "_bytes"}, o_bytes_checked, 0);
      check_eq({tag, "_fev"},   32'(o_first_err_valid), 0);
      check_eq({tag, "_fea"},   32'(o_first_err_addr), 0);
      check_eq({tag, "_fee"},   32'(o_first_err_exp), 0);
      check_eq({tag, "_fac"},   32'(o_first_err_act), 0);
   endtask

   // One run: model results come from the pattern formula, stream[] is the fed data.
   task automatic run(input string tag, input int sel, input logic [AW-1:0] addr,
                      input int gap_pct, input bit mid_start, input int abort_after);
      int         exp_bytes, exp_err, first_idx, idx, run_err, cyc, last_acc;
      bit         done_seen, acc_prev, mid_done, fin;
      logic [7:0] e;

      first_idx = -1;
      exp_err   = 0;
      for (int n = 0; n < N; n++) begin
         if (stream[n] != exp_byte(sel, n) && first_idx < 0) first_idx = n;
      end
      exp_bytes = (STOP && first_idx >= 0) ? first_idx + 1 : N;
      for (int n = 0; n < exp_bytes; n++) begin
         if (stream[n] != exp_byte(sel, n)) exp_err++;
      end

      @(negedge clk);
      i_start       = 1'b1;
      i_pattern_sel = 2'(sel);
      i_start_addr  = addr;
      @(negedge clk);
      i_start       = 1'b0;
      i_pattern_sel = 2'($urandom);
      i_start_addr  = AW'($urandom);
      check_eq({tag, "_busy_start"}, 32'(o_busy), 1);
      check_eq({tag, "_pass_clr"},   32'(o_pass), 0);
      check_eq({tag, "_bytes_clr"},  o_bytes_checked, 0);

      idx = 0; run_err = 0; cyc = 0; last_acc = -10;
      done_seen = 0; acc_prev = 0; mid_done = 0; fin = 0;
      while (!fin && cyc < 400) begin
         if (acc_prev) begin
            check_eq({tag, "_err_run"},   o_err_count, 32'(run_err));
            check_eq({tag, "_bytes_run"}, o_bytes_checked, 32'(idx));
            check_eq({tag, "_fev_run"},   32'(o_first_err_valid), 32'(run_err > 0));
         end
         i_start = 1'b0;
         if (o_done) begin
            done_seen = 1;
            fin       = 1;
            check_eq({tag, "_done_lat"},   32'(cyc - last_acc), 1);
            check_eq({tag, "_accepts"},    32'(idx), 32'(exp_bytes));
            check_eq({tag, "_ready_done"}, 32'(o_rd_ready), 0);
         end else if (abort_after > 0 && idx == abort_after) begin
            i_rd_valid = 1'b0;
            rst        = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_all_zero({tag, "_rst"});
            @(negedge clk);
            check_eq({tag, "_rst_nodone"}, 32'(o_done), 0);
            check_eq({tag, "_rst_idle"},   32'(o_busy), 0);
            return;
         end else begin
            if (mid_start && !mid_done && idx == 6) begin
               i_start       = 1'b1;
               i_pattern_sel = 2'd0;
               i_start_addr  = AW'($urandom);
               mid_done      = 1;
            end
            i_rd_valid = (idx < N) && ($urandom_range(99) >= gap_pct);
            i_rd_data  = i_rd_valid ? stream[idx] : 8'($urandom);
            acc_prev   = i_rd_valid && o_rd_ready;
            if (acc_prev) begin
               e = exp_byte(sel, idx);
               if (stream[idx] != e) run_err++;
               idx++;
               last_acc = cyc;
            end
            @(negedge clk);
            cyc++;
         end
      end
      i_rd_valid = 1'b0;
      i_start    = 1'b0;
      if (!done_seen) check_eq({tag, "_done_timeout"}, 0, 1);

      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 32'(o_done), 0);
      check_eq({tag, "_busy_end"},   32'(o_busy), 0);
      check_eq({tag, "_pass"},       32'(o_pass), 32'(exp_err == 0));
      check_eq({tag, "_err"},        o_err_count, 32'(exp_err));
      check_eq({tag, "_bytes"},      o_bytes_checked, 32'(exp_bytes));
      check_eq({tag, "_fev"},        32'(o_first_err_valid), 32'(first_idx >= 0));
      if (first_idx >= 0) begin
         check_eq({tag, "_fea"}, 32'(o_first_err_addr), 32'(AW'(addr + AW'(first_idx))));
         check_eq({tag, "_fee"}, 32'(o_first_err_exp),  32'(exp_byte(sel, first_idx)));
         check_eq({tag, "_fac"}, 32'(o_first_err_act),  32'(stream[first_idx]));
      end
      repeat (3) @(negedge clk);
      check_eq({tag, "_hold_err"}, o_err_count, 32'(exp_err));
      check_eq({tag, "_hold_pass"}, 32'(o_pass), 32'(exp_err == 0));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset");

      set_good(0);                         run("t1_a_clean", 0, 25'h0, 0, 0, 0);
      set_good(1); stream[3] = 8'hFF;      run("t2_b_err3", 1, 25'h001000, 0, 0, 0);
      check_eq("t2_exp_is_1d", 32'(exp_byte(1, 3)), 32'h1D);
      set_good(3);                         run("t3_d_wrap", 3, 25'h0, 0, 0, 0);
      check_eq("t3_byte11_is_15", 32'(exp_byte(3, 11)), 32'h15);
      set_good(3); stream[11] = 8'h14;     run("t3_d_bad11", 3, 25'h0, 0, 0, 0);
      set_good(2);                         run("t4_c_nogap", 2, 25'h0ABCDE, 0, 0, 0);
      set_good(2);                         run("t4_c_gaps", 2, 25'h0ABCDE, 40, 1, 0);
      set_good(2); stream[9] = 8'h00;      run("t4_c_gaps_err", 2, 25'h0ABCDE, 40, 1, 0);
      set_good(0);                         run("t5_abort", 0, 25'h0, 0, 0, 5);
      set_good(0);                         run("t5_restart", 0, 25'h0, 0, 0, 0);
      set_good(0); stream[2] = 8'hAA;      run("t6_a_err2", 0, 25'h0, 0, 0, 0);
      set_good(1); stream[4] = 8'h5A;      run("t7_addr_wrap", 1, 25'h1FFFFFE, 20, 0, 0);

      for (int r = 0; r < 8; r++) begin
         int sel;
         sel = int'($urandom_range(3));
         set_good(sel);
         for (int n = 0; n < N; n++) begin
            if ($urandom_range(5) == 0) stream[n] = stream[n] ^ 8'($urandom_range(255, 1));
         end
         run($sformatf("rand%0d", r), sel, AW'($urandom), int'($urandom_range(50)), r[0], 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
